float_operand_entry: RTL

Keypad-to-operand assembler that sits directly upstream of the float32 adder/subtractor. It turns one-cycle hex nibble strobes (from the keypad scanner) and edit commands into two live 32-bit working operands (A, B) for the LCD. On commit it presents a frozen operand pair to the adder stage over a valid/ready handshake. It replaces ad-hoc nibble poking in the top level with a single clocked, reset-clean entry path.

---
 rtl/float_operand_entry.sv | 98 +++++++++
 1 files changed

// File: rtl/float_operand_entry.sv
// float_operand_entry: keypad nibble/edit entry into two operand rows with a valid/ready commit stage (FLOAT_ENTRY_EXPO_KEYS_EN enables exponent keys)
module float_operand_entry #(
  parameter int WIDTH       = 32,
  parameter bit AUTO_COMMIT = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             key_valid,
  input  logic [3:0]       key_nibble,
  input  logic             row_sel,
  input  logic             cmd_clear,
  input  logic             cmd_back,
  input  logic             cmd_expo_inc,
  input  logic             cmd_expo_dec,
  input  logic             cmd_expo_one,
  input  logic             commit,
  output logic [WIDTH-1:0] work_a,
  output logic [WIDTH-1:0] work_b,
  output logic [3:0]       cursor_a,
  output logic [3:0]       cursor_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NIBBLES = WIDTH / 4;
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sel_row, new_row, next_a, next_b;
  logic [3:0] sel_cur, new_cur, next_ca, next_cb;
  logic fill_b, commit_now, capture;
`ifndef FLOAT_ENTRY_EXPO_KEYS_EN
  logic unused_expo;
  assign unused_expo = ^{cmd_expo_inc, cmd_expo_dec, cmd_expo_one};
`endif
  // Apply the single highest-priority edit to the selected row; the other row passes through
  always_comb begin
    sel_row = row_sel ? work_b : work_a;
    sel_cur = row_sel ? cursor_b : cursor_a;
    new_row = sel_row;
    new_cur = sel_cur;
    fill_b = 1'b0;
    if (cmd_clear) begin
      new_row = '0;
      new_cur = '0;
    end else if (cmd_back) begin
      if (sel_cur != 4'd0) begin
        new_cur = sel_cur - 4'd1;
        new_row[WIDTH-4-4*int'(new_cur) +: 4] = 4'h0;
      end
    end else if (key_valid) begin
      if (sel_cur < 4'(NIBBLES)) begin
        new_row[WIDTH-4-4*int'(sel_cur) +: 4] = key_nibble;
        new_cur = sel_cur + 4'd1;
        fill_b = row_sel && (sel_cur == 4'(NIBBLES-1));
      end
    end
`ifdef FLOAT_ENTRY_EXPO_KEYS_EN
    else if (cmd_expo_one)
      new_row[30:23] = 8'd127;
    else
      new_row[30:23] = sel_row[30:23] + {7'd0, cmd_expo_inc} - {7'd0, cmd_expo_dec};
`endif
    next_a  = row_sel ? work_a : new_row;
    next_b  = row_sel ? new_row : work_b;
    next_ca = row_sel ? cursor_a : new_cur;
    next_cb = row_sel ? new_cur : cursor_b;
  end
  // Handshake FSM: a commit is only taken when no pair is pending or the pending one is leaving
  always_comb begin
    commit_now = commit || (AUTO_COMMIT && fill_b);
    capture = commit_now && (state == IDLE || out_ready);
    state_n = (state == IDLE || out_ready) ? (commit_now ? PEND : IDLE) : PEND;
  end
  assign out_valid = (state == PEND);
  // Working rows, cursors, frozen pair and FSM state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      work_a   <= '0;
      work_b   <= '0;
      cursor_a <= '0;
      cursor_b <= '0;
      out_a    <= '0;
      out_b    <= '0;
      state    <= IDLE;
    end else begin
      work_a   <= next_a;
      work_b   <= next_b;
      cursor_a <= next_ca;
      cursor_b <= next_cb;
      state    <= state_n;
      if (capture) begin
        out_a <= next_a;
        out_b <= next_b;
      end
    end
  end
endmodule
